// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single regfile write port between the in-order
// write-back stage (always first) and a small FIFO of multi-cycle async results.
// An age counter on the FIFO head requests a pipeline stall so buffered results
// always drain, and a busy bitmap flags registers with outstanding async writes.
//
// Async result handshake: a result transfers on a posedge where as_valid_i and
// as_ready_o are both 1; as_ready_o depends only on buffer occupancy and rst,
// never on as_valid_i, and a transferred result addressed to r0 is discarded.
module rf_wport_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic              as_valid_i,
  output logic              as_ready_o,
  input  logic [ADDR_W-1:0] as_addr_i,
  input  logic [DATA_W-1:0] as_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              rd1_busy_o,
  output logic              rd2_busy_o,
  output logic              stall_req_o
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int NREG   = 1 << ADDR_W;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] buf_addr_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              wb_win;
  logic              buf_nonempty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign wb_win       = wb_we_i && (wb_waddr_i != '0);
  assign buf_nonempty = (count_q != '0);
  assign head_addr    = buf_addr_q[rd_ptr_q];
  assign head_data    = buf_data_q[rd_ptr_q];
  assign as_ready_o   = !rst && (count_q < CNT_W'(BUF_DEPTH));
  assign push         = as_valid_i && as_ready_o && (as_addr_i != '0);
  assign pop          = !rst && !wb_win && buf_nonempty;

  // Write-port mux: write-back wins, otherwise drain the FIFO head
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (!rst) begin
      if (wb_win) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = wb_waddr_i;
        rf_wdata_o = wb_wdata_i;
      end else if (buf_nonempty) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = head_addr;
        rf_wdata_o = head_data;
      end
    end
  end

  // Next-state for pointers, occupancy, head age counter and busy bitmap
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;
    busy_d   = busy_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Age of the head entry: reset when it leaves or nothing is queued
    if (!buf_nonempty || pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Clear on commit first so a same-cycle reissue keeps the bit set
    if (pop) busy_d[head_addr] = 1'b0;
    if (iss_valid_i && (iss_addr_i != '0)) busy_d[iss_addr_i] = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      busy_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO payload; validity is tracked by count_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= as_addr_i;
      buf_data_q[wr_ptr_q] <= as_data_i;
    end
  end

  // Registered stall request and combinational scoreboard lookups
  assign stall_req_o = !rst && (wait_q == WAIT_W'(MAX_WAIT));
  assign rd1_busy_o  = !rst && busy_q[raddr1_i] && (raddr1_i != '0);
  assign rd2_busy_o  = !rst && busy_q[raddr2_i] && (raddr2_i != '0);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: cycle-by-cycle vectors for rf_wport_arbiter. Each row holds
// one cycle of inputs plus the outputs expected during that cycle (before the edge).
module tb_rf_wport_arbiter;

  typedef struct {
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        iss_v;
    logic [4:0]  iss_a;
    logic        as_v;
    logic [4:0]  as_a;
    logic [31:0] as_d;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_b1;
    logic        e_b2;
    logic        e_st;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wb_we, iss_valid, as_valid;
  logic [4:0]  wb_waddr, iss_addr, as_addr, raddr1, raddr2;
  logic [31:0] wb_wdata, as_data;
  logic        as_ready, rf_we, rd1_busy, rd2_busy, stall_req;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  rf_wport_arbiter #(.DATA_W(32), .ADDR_W(5), .BUF_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
    .as_valid_i(as_valid), .as_ready_o(as_ready), .as_addr_i(as_addr), .as_data_i(as_data),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .rd1_busy_o(rd1_busy), .rd2_busy_o(rd2_busy), .stall_req_o(stall_req)
  );

  // driver: apply one row at the falling edge, compare 1 ns later
  task automatic apply_row(input string name, input int idx, input vec_t v);
    logic [41:0] act, exp;
    @(negedge clk);
    rst       = v.rst;
    wb_we     = v.wb_we;   wb_waddr = v.wb_wa; wb_wdata = v.wb_wd;
    iss_valid = v.iss_v;   iss_addr = v.iss_a;
    as_valid  = v.as_v;    as_addr  = v.as_a;  as_data  = v.as_d;
    raddr1    = v.ra1;     raddr2   = v.ra2;
    #1;
    act = {as_ready, rf_we, rf_waddr, rf_wdata, rd1_busy, rd2_busy, stall_req};
    exp = {v.e_rdy, v.e_we, v.e_wa, v.e_wd, v.e_b1, v.e_b2, v.e_st};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got rdy=%b we=%b wa=%0d wd=%h b1=%b b2=%b st=%b, want rdy=%b we=%b wa=%0d wd=%h b1=%b b2=%b st=%b",
               name, idx, as_ready, rf_we, rf_waddr, rf_wdata, rd1_busy, rd2_busy, stall_req,
               v.e_rdy, v.e_we, v.e_wa, v.e_wd, v.e_b1, v.e_b2, v.e_st);
    end
  endtask

  vec_t tbl[18];
  vec_t v;

  initial begin
    wb_we = 0; wb_waddr = 0; wb_wdata = 0; iss_valid = 0; iss_addr = 0;
    as_valid = 0; as_addr = 0; as_data = 0; raddr1 = 0; raddr2 = 0;

    //        rst   wbwe  wbwa   wbwd          issv  issa   asv   asa    asd           ra1    ra2    rdy   we    wa     wd            b1    b2    st
    // reset gating, single async write + scoreboard, r0 handling
    tbl[0]  = '{1'b1, 1'b1, 5'd7,  32'h000000AA, 1'b0, 5'd0,  1'b1, 5'd5,  32'h00000001, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd5,  32'h00001234, 5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b1, 1'b1, 5'd5,  32'h00001234, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd9,  32'h0000DEAD, 5'd9,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b1, 1'b1, 5'd9,  32'h0000DEAD, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd9,  32'h00000077, 5'd9,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b1, 1'b1, 5'd9,  32'h00000077, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd0,  32'h00000055, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 5'd7,  32'h00001111, 1'b0, 5'd0,  1'b1, 5'd3,  32'h00003333, 5'd0,  5'd0,  1'b1, 1'b1, 5'd7,  32'h00001111, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 5'd0,  32'h00002222, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 1'b1, 5'd3,  32'h00003333, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) apply_row("table", i, tbl[i]);

    // head ages behind continuous write-back until stall_req, then drains
    v = '{1'b0, 1'b1, 5'd7, 32'h00000700, 1'b0, 5'd0, 1'b1, 5'd3, 32'h000000C3, 5'd0, 5'd0,
          1'b1, 1'b1, 5'd7, 32'h00000700, 1'b0, 1'b0, 1'b0};
    apply_row("age_push", 0, v);
    for (int i = 0; i < 6; i++) begin
      v = '{1'b0, 1'b1, 5'd7, 32'h00000700 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
            1'b1, 1'b1, 5'd7, 32'h00000700 + 32'(i), 1'b0, 1'b0, (i >= 4)};
      apply_row("age_wait", i, v);
    end
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
          1'b1, 1'b1, 5'd3, 32'h000000C3, 1'b0, 1'b0, 1'b1};
    apply_row("age_drain", 0, v);
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
          1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0};
    apply_row("age_after", 0, v);

    // fill to capacity, backpressure the third result, drain in order
    v = '{1'b0, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h1, 1'b0, 1'b0, 1'b0};
    apply_row("full", 0, v);
    v = '{1'b0, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 1'b1, 5'd11, 32'hB0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h2, 1'b0, 1'b0, 1'b0};
    apply_row("full", 1, v);
    v = '{1'b0, 1'b1, 5'd7, 32'h3, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h3, 1'b0, 1'b0, 1'b0};
    apply_row("full", 2, v);
    v = '{1'b0, 1'b1, 5'd7, 32'h4, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h4, 1'b0, 1'b0, 1'b0};
    apply_row("full", 3, v);
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b0};
    apply_row("full", 4, v);
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 32'hB0, 1'b0, 1'b0, 1'b0};
    apply_row("full", 5, v);
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0, 1'b0};
    apply_row("full", 6, v);
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0};
    apply_row("full", 7, v);

    // reset while two entries are buffered and stall_req is high
    v = '{1'b0, 1'b1, 5'd7, 32'h7, 1'b1, 5'd13, 1'b1, 5'd13, 32'h1, 5'd13, 5'd0, 1'b1, 1'b1, 5'd7, 32'h7, 1'b0, 1'b0, 1'b0};
    apply_row("rst_mid", 0, v);
    v = '{1'b0, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 1'b1, 5'd14, 32'h2, 5'd13, 5'd0, 1'b1, 1'b1, 5'd7, 32'h7, 1'b1, 1'b0, 1'b0};
    apply_row("rst_mid", 1, v);
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0, 1'b0, 1'b1, 5'd7, 32'h7, 1'b1, 1'b0, (i == 3)};
      apply_row("rst_mid_wait", i, v);
    end
    v = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0};
    apply_row("rst_mid_rst", 0, v);
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd14, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0};
      apply_row("rst_mid_after", i, v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
